// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg : shared constants and types for the fetch / control-unit boundary.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int OP_W     = 5;
    localparam int OP_MSB   = 31;
    localparam int COND_W   = 2;
    localparam int COND_MSB = 26;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_ILL = 2'b11;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic is_redirect_src(input logic [1:0] src);
        return (src == PCSRC_BR) || (src == PCSRC_JR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ----------------------------------------------------------------------------
// fetch_skid_buf : one-entry instruction+PC holding buffer (load/pop/clear).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_pop,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    // Clear beats load: a redirect discards any wrong-path entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit : PC owner, single-outstanding imem fetch, IF/ID register.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_en,
    input  logic [1:0]         pc_source,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  jr_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus1,
    output logic [OP_W-1:0]    if_op,
    output logic [COND_W-1:0]  if_cond,
    output logic               err_illegal_src
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_req_pc;
    logic               r_if_valid;
    logic [INSTR_W-1:0] r_if_instr;
    logic [ADDR_W-1:0]  r_if_pc;
    logic               r_err;

    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc;

    logic               w_redirect;
    logic [ADDR_W-1:0]  w_target;
    logic               w_req;
    logic               w_accept;
    logic               w_resp;
    logic               w_consume;
    logic               w_skid_load;
    logic               w_skid_pop;

    assign w_redirect = redirect_en && is_redirect_src(pc_source);
    assign w_target   = (pc_source == PCSRC_JR) ? jr_target : branch_target;
    assign w_req      = !reset && (r_state == REQ) && !w_skid_valid;
    assign w_accept   = w_req && imem_ready;
    assign w_resp     = (r_state == WAIT) && imem_rvalid;
    assign w_consume  = r_if_valid && !stall;

    // A response parks in the skid when IF/ID stays occupied, or when IF/ID
    // is being refilled from the skid in the same cycle.
    assign w_skid_load = w_resp && r_if_valid && (!w_consume || w_skid_valid);
    assign w_skid_pop  = w_consume && w_skid_valid;

    fetch_skid_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_pop   (w_skid_pop),
        .i_clear (w_redirect),
        .i_instr (imem_rdata),
        .i_pc    (r_req_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (redirect_en && (pc_source == PCSRC_ILL)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                REQ: begin
                    if (w_accept) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                        r_state    <= w_redirect ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= REQ;
                    end else if (w_redirect) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase

            // Redirect target overrides the sequential increment above.
            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end

            if (w_redirect) begin
                r_if_valid <= 1'b0;
            end else if (w_consume) begin
                if (w_skid_valid) begin
                    r_if_instr <= w_skid_instr;
                    r_if_pc    <= w_skid_pc;
                end else if (w_resp) begin
                    r_if_instr <= imem_rdata;
                    r_if_pc    <= r_req_pc;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end else if (w_resp && !r_if_valid) begin
                r_if_valid <= 1'b1;
                r_if_instr <= imem_rdata;
                r_if_pc    <= r_req_pc;
            end
        end
    end

    assign imem_req        = w_req;
    assign imem_addr       = r_fetch_pc;
    assign if_valid        = r_if_valid;
    assign if_instr        = r_if_instr;
    assign if_pc           = r_if_pc;
    assign if_pc_plus1     = r_if_pc + ADDR_W'(1);
    assign if_op           = r_if_instr[OP_MSB -: OP_W];
    assign if_cond         = r_if_instr[COND_MSB -: COND_W];
    assign err_illegal_src = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit : random fetch traffic against an in-order PC-stream model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [1:0]  pc_source = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jr_target = '0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus1;
    logic [4:0]  if_op;
    logic [1:0]  if_cond;
    logic        err_illegal_src;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (RPC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .pc_source       (pc_source),
        .branch_target   (branch_target),
        .jr_target       (jr_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus1     (if_pc_plus1),
        .if_op           (if_op),
        .if_cond         (if_cond),
        .err_illegal_src (err_illegal_src)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    int ncons = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          pending = 1'b0;
    logic [31:0] paddr = '0;
    int          cnt = 0;
    int          lat_force = 0;
    bit          hold_ready = 1'b0;
    bit          full_ready = 1'b1;
    bit          held_valid = 1'b0;
    logic [31:0] held_addr = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pending) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pending     = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_ready = hold_ready ? 1'b0 : (full_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
            @(negedge clk);
            if (!reset && imem_req) begin
                chk("one_outstanding", 32'(pending), 32'd0);
                if (held_valid) chk("addr_stable", imem_addr, held_addr);
                if (imem_ready) begin
                    pending    = 1'b1;
                    paddr      = imem_addr;
                    cnt        = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 2));
                    held_valid = 1'b0;
                end else begin
                    held_valid = !(redirect_en && (pc_source == 2'b01 || pc_source == 2'b10));
                    held_addr  = imem_addr;
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    bit          err_exp = 1'b0;
    bit          redir;
    logic [31:0] e_pc;
    logic [31:0] e_word;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                exp_q.push_back(RPC);
                err_exp = 1'b0;
            end else begin
                redir = redirect_en && (pc_source == 2'b01 || pc_source == 2'b10);
                chk("err_illegal_src", 32'(err_illegal_src), 32'(err_exp));
                if (if_valid && (!stall || redir)) begin
                    e_pc   = exp_q.pop_front();
                    e_word = mem_word(e_pc);
                    ncons++;
                    chk("if_pc", if_pc, e_pc);
                    chk("if_instr", if_instr, e_word);
                    chk("if_op", 32'(if_op), 32'(e_word[31:27]));
                    chk("if_cond", 32'(if_cond), 32'(e_word[26:25]));
                    chk("if_pc_plus1", if_pc_plus1, e_pc + 32'd1);
                end
                if (redir) begin
                    exp_q.delete();
                    exp_q.push_back((pc_source == 2'b10) ? jr_target : branch_target);
                end
                while (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd1);
                if (redirect_en && pc_source == 2'b11) err_exp = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int n);
        full_ready = 1'b0;
        lat_force  = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            stall         = ($urandom_range(0, 3) == 0);
            redirect_en   = ($urandom_range(0, 11) == 0);
            pc_source     = 2'($urandom_range(0, 3));
            branch_target = $urandom;
            jr_target     = $urandom;
        end
        @(posedge clk);
        #1;
        stall       = 1'b0;
        redirect_en = 1'b0;
    endtask

    logic [31:0] held_pc;
    bit          found;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_err", 32'(err_illegal_src), 32'd0);
        chk("rst_imem_addr", imem_addr, RPC);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RPC);

        cycles(20);

        // Stall long enough to fill IF/ID and the skid.
        stall = 1'b1;
        repeat (3) @(negedge clk);
        held_pc = if_pc;
        repeat (8) @(negedge clk);
        chk("skid_full_noreq", 32'(imem_req), 32'd0);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_hold_pc", if_pc, held_pc);
        @(posedge clk);
        #1 stall = 1'b0;
        cycles(10);

        random_phase(400);

        // Wrap-around of the fetch PC.
        full_ready = 1'b1;
        lat_force  = 0;
        redirect_en = 1'b1; pc_source = 2'b01; branch_target = 32'hFFFF_FFFE;
        cycles(1);
        redirect_en = 1'b0;
        cycles(14);

        // Illegal source: sticky error, no redirect.
        redirect_en = 1'b1; pc_source = 2'b11; branch_target = 32'h0000_0040;
        cycles(1);
        redirect_en = 1'b0; pc_source = 2'b00;
        cycles(5);
        @(negedge clk);
        chk("err_sticky", 32'(err_illegal_src), 32'd1);

        // Reset while a request is outstanding, stale response after reset.
        lat_force = 1;
        found     = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_ready) found = 1'b1;
        end
        chk("rst_test_accept", 32'(found), 32'd1);
        hold_ready = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_if_valid", 32'(if_valid), 32'd0);
        chk("rst2_imem_addr", imem_addr, RPC);
        chk("rst2_imem_req", 32'(imem_req), 32'd1);
        chk("rst2_err", 32'(err_illegal_src), 32'd0);
        @(negedge clk);
        chk("stale_ignored", 32'(if_valid), 32'd0);
        hold_ready = 1'b0;

        random_phase(300);
        cycles(12);
        chk("progress", 32'(ncons >= 150), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

`default_nettype wire
